// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge channel between the fetch stage
// (master) and the instruction memory (slave).
interface fetch_stage_if;
  localparam int unsigned XLEN = 32;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [XLEN-1:0] data;

  modport master (output req, addr, input ack, data);
  modport slave  (input req, addr, output ack, data);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ack handshake, one-entry skid buffer
// and the IF/ID register (ir1/pc1), steered by hazard stalls and EX redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 isstall1_i,
  input  logic                 isstall2_i,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i,
  fetch_stage_if.master        imem,
  output logic [31:0]          ir1_o,
  output logic [31:0]          pc1_o
);
  localparam int unsigned XLEN   = 32;
  localparam logic [XLEN-1:0] NOP_IR = 32'hF000_0000;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUF, S_KILL} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_ir_q, buf_ir_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [XLEN-1:0] kill_addr_q, kill_addr_d;
  logic [XLEN-1:0] ir1_q, ir1_d;
  logic [XLEN-1:0] pc1_q, pc1_d;
  logic            advance;
  logic            loaded;

  assign advance = ~isstall1_i & ~isstall2_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      buf_ir_q    <= NOP_IR;
      buf_pc_q    <= '0;
      kill_addr_q <= '0;
      ir1_q       <= NOP_IR;
      pc1_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_ir_q    <= buf_ir_d;
      buf_pc_q    <= buf_pc_d;
      kill_addr_q <= kill_addr_d;
      ir1_q       <= ir1_d;
      pc1_q       <= pc1_d;
    end
  end

  // Next-state: redirect overrides stalls and any ack arriving the same cycle.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_ir_d    = buf_ir_q;
    buf_pc_d    = buf_pc_q;
    kill_addr_d = kill_addr_q;
    ir1_d       = ir1_q;
    pc1_d       = pc1_q;
    loaded      = 1'b0;

    if (redirect_i) begin
      pc_d   = redirect_pc_i & ~XLEN'(3);
      ir1_d  = NOP_IR;
      pc1_d  = '0;
      loaded = 1'b1;
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (!imem.ack) begin
            kill_addr_d = pc_q;
            state_d     = S_KILL;
          end
        end
        S_BUF:   state_d = S_REQ;
        S_KILL:  state_d = S_KILL;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem.ack) begin
            pc_d = pc_q + PC_INC;
            if (advance) begin
              ir1_d  = imem.data;
              pc1_d  = pc_q;
              loaded = 1'b1;
            end else begin
              buf_ir_d = imem.data;
              buf_pc_d = pc_q;
              state_d  = S_BUF;
            end
          end
        end
        S_BUF: begin
          if (advance) begin
            ir1_d   = buf_ir_q;
            pc1_d   = buf_pc_q;
            loaded  = 1'b1;
            state_d = S_REQ;
          end
        end
        S_KILL: begin
          if (imem.ack) state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Bubble into IF/ID when nothing was loaded and decode is not holding.
    if (!loaded && !isstall2_i) begin
      ir1_d = NOP_IR;
      pc1_d = '0;
    end
  end

  assign imem.req  = (state_q == S_REQ) || (state_q == S_KILL);
  assign imem.addr = (state_q == S_KILL) ? kill_addr_q : pc_q;
  assign ir1_o     = ir1_q;
  assign pc1_o     = pc1_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model with programmable ack
// latency and a scoreboard of accepted fetches in program order.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP_IR   = 32'hF000_0000;
  localparam logic [31:0] MAGIC    = 32'h5A00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        isstall1, isstall2, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ir1, pc1;

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .isstall1_i   (isstall1),
    .isstall2_i   (isstall2),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .imem         (imem),
    .ir1_o        (ir1),
    .pc1_o        (pc1)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned lat      = 0;
  int unsigned wait_cnt = 0;
  logic        force_ack = 1'b0;
  logic        acked_last = 1'b0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] last_ir = NOP_IR;
  logic [31:0] last_pc = '0;
  logic [63:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // One clock: drive the memory response, log expectations, then check IF/ID.
  task automatic tick();
    logic        a, acc, p_rst, p_red, p_s1, p_s2;
    logic [63:0] e;
    a = 1'b0;
    if (force_ack) a = 1'b1;
    else if (imem.req) begin
      if (wait_cnt >= lat) begin a = 1'b1; wait_cnt = 0; end
      else wait_cnt++;
    end else wait_cnt = 0;
    imem.ack  = a;
    imem.data = a ? (imem.addr ^ MAGIC) : 32'h0;
    acc   = imem.req & a;
    p_rst = rst; p_red = redirect; p_s1 = isstall1; p_s2 = isstall2;
    if (p_rst) begin
      sb_q.delete(); exp_pc = RESET_PC;
    end else if (p_red) begin
      sb_q.delete(); exp_pc = redirect_pc & ~32'd3;
    end else if (acc && imem.addr == exp_pc) begin
      sb_q.push_back({imem.addr ^ MAGIC, imem.addr});
      exp_pc = exp_pc + 32'd4;
    end
    acked_last = acc;
    @(posedge clk);
    @(negedge clk);
    imem.ack = 1'b0;
    if (p_rst || p_red || (p_s1 && !p_s2) || (!p_s1 && !p_s2 && sb_q.size() == 0)) begin
      last_ir = NOP_IR; last_pc = '0;
    end else if (!p_s2) begin
      e = sb_q.pop_front();
      last_ir = e[63:32]; last_pc = e[31:0];
    end
    check_eq("ir1", ir1, last_ir);
    check_eq("pc1", pc1, last_pc);
  endtask

  initial begin
    logic [31:0] t;
    int          n;
    rst = 1'b1; isstall1 = 1'b0; isstall2 = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem.ack = 1'b0; imem.data = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_req", 32'(imem.req), 32'd0);
    check_eq("rst_addr", imem.addr, RESET_PC);
    check_eq("rst_ir1", ir1, NOP_IR);
    check_eq("rst_pc1", pc1, 32'd0);

    // Zero-wait streaming
    rst = 1'b0; lat = 0;
    tick();
    check_eq("first_req", 32'(imem.req), 32'd1);
    check_eq("addr0", imem.addr, 32'h100);
    tick();
    check_eq("addr1", imem.addr, 32'h104);
    tick();
    check_eq("addr2", imem.addr, 32'h108);
    tick();
    check_eq("addr3", imem.addr, 32'h10C);

    // Full stall while 0x10C is acked: goes to the skid buffer
    isstall1 = 1'b1; isstall2 = 1'b1;
    repeat (3) tick();
    check_eq("buf_req", 32'(imem.req), 32'd0);
    isstall1 = 1'b0; isstall2 = 1'b0;
    tick();
    check_eq("rel_pc1", pc1, 32'h10C);
    check_eq("rel_addr", imem.addr, 32'h110);

    // PC stall only: bubbles into IF/ID
    isstall1 = 1'b1;
    repeat (2) tick();
    isstall1 = 1'b0;
    tick();
    check_eq("pcs_pc1", pc1, 32'h110);
    check_eq("pcs_addr", imem.addr, 32'h114);

    // Redirect to 0x40 with coincident ack, then kill an outstanding 0x40 request
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    check_eq("redir40_addr", imem.addr, 32'h40);
    lat = 3;
    tick();
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    n = 0;
    while (!acked_last && n < 10) begin
      check_eq("kill_addr", imem.addr, 32'h40);
      tick();
      n++;
    end
    check_eq("kill_acked", 32'(acked_last), 32'd1);
    check_eq("tgt_req", 32'(imem.req), 32'd1);
    check_eq("tgt_addr", imem.addr, 32'h200);
    lat = 0;
    repeat (3) tick();

    // Redirect coincident with ack and IF/ID hold
    isstall2 = 1'b1; redirect = 1'b1; redirect_pc = 32'h303;
    tick();
    isstall2 = 1'b0; redirect = 1'b0;
    check_eq("r300_addr", imem.addr, 32'h300);
    repeat (2) tick();

    // Asynchronous reset with a request outstanding, then a late ack
    lat = 5;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_req", 32'(imem.req), 32'd0);
    check_eq("arst_addr", imem.addr, RESET_PC);
    check_eq("arst_ir1", ir1, NOP_IR);
    check_eq("arst_pc1", pc1, 32'd0);
    force_ack = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    force_ack = 1'b0;
    check_eq("arst_restart", imem.addr, RESET_PC);
    lat = 0;
    repeat (2) tick();

    // Random stalls, latencies and redirects
    for (int i = 0; i < 300; i++) begin
      isstall1 = ($urandom_range(0, 3) == 0);
      isstall2 = ($urandom_range(0, 3) == 0);
      lat      = $urandom_range(0, 2);
      redirect = ($urandom_range(0, 19) == 0);
      t = 32'h8000 + 32'($urandom_range(0, 255)) * 32'd4;
      if (t == (imem.addr & ~32'd3)) t = t + 32'd4;
      redirect_pc = t | 32'($urandom_range(0, 3));
      tick();
      redirect = 1'b0;
    end

    // Drain
    isstall1 = 1'b0; isstall2 = 1'b0; lat = 0;
    repeat (4) tick();
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined CPU: holds the PC, runs a req/ack handshake with instruction memory, and drives the IF/ID pipeline register (ir1/pc1) consumed by decode and by the hazard unit. It obeys the hazard unit's stall outputs (PC stall, IF/ID stall) and the taken-branch/jump redirect from EX. A one-entry skid buffer keeps an instruction that arrives during a stall, so no fetch is lost or repeated.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_IR, 32'hF000_0000, bubble word (opcode 4'b1111, unused by the ALU decode)
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset; asynchronous, active-high
- isstall1_i  input  1  PC stall from hazard unit
- isstall2_i  input  1  IF/ID hold from hazard unit
- redirect_i  input  1  taken branch/jump from EX; one-cycle pulse
- redirect_pc_i  input  32  redirect target, valid with redirect_i
- imem_req_o  output  1  fetch request
- imem_addr_o  output  32  fetch address, word aligned
- imem_ack_i  input  1  fetch complete; data valid this cycle
- imem_data_i  input  32  fetched instruction
- ir1_o  output  32  IF/ID instruction register
- pc1_o  output  32  IF/ID PC register

## Operation
- Registers: pc_q (next fetch address), state, buf_ir/buf_pc, kill_addr_q, ir1_o, pc1_o.
- Advance = isstall1_i=0 and isstall2_i=0.
- Handshake: while imem_req_o=1, imem_addr_o stays stable until the cycle imem_ack_i=1. A new request can start the next cycle (req may stay high back-to-back). imem_ack_i is ignored while req=0.
- States:
  - S_IDLE: req=0. Entered only by reset. Goes to S_REQ next clock.
  - S_REQ: req=1, addr=pc_q. On ack with advance: ir1<=data, pc1<=pc_q, pc_q+=4, stay. On ack without advance: buf<=data/pc_q, pc_q+=4, go S_BUF. No ack: stay.
  - S_BUF: req=0. On advance: ir1<=buf_ir, pc1<=buf_pc, go S_REQ. Otherwise stay.
  - S_KILL: req=1, addr=kill_addr_q. Wait for ack, discard data, go S_REQ.
- IF/ID update when nothing is loaded: isstall2_i=1 holds ir1/pc1. isstall2_i=0 loads ir1<=NOP_IR, pc1<=0.
- Redirect (highest priority, beats stalls and ack):
  - pc_q<=redirect_pc_i. IF/ID flushed: ir1<=NOP_IR, pc1<=0, even if isstall2_i=1. Buffer dropped.
  - S_REQ without ack: kill_addr_q<=pc_q, go S_KILL.
  - S_REQ with ack: drop data, stay S_REQ.
  - S_BUF: go S_REQ.
  - S_KILL: stay S_KILL, keep kill_addr_q.
  - S_IDLE: pc_q loaded, go S_REQ.
- pc_q increments by 4 modulo 2^32 (0xFFFF_FFFC wraps to 0). redirect_pc_i[1:0] is ignored and treated as 00.

## Timing
- Reset values: state=S_IDLE, pc_q=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, ir1_o=NOP_IR, pc1_o=0, buffer empty.
- Reset asserted mid-transaction: the request is abandoned immediately; any late ack after reset is ignored because state is S_IDLE.
- First request appears in the first cycle after the first clock edge following rst_i deassertion.
- Zero-wait memory (ack in the request cycle), no stalls: one instruction per cycle. An ack in cycle n makes ir1_o/pc1_o valid after edge n.
- Buffered instruction: reaches ir1 on the first edge with advance. The next request issues the cycle after.
- Redirect during an outstanding request: the first target request issues the cycle after the killed ack.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Test plan
- Reset, RESET_PC=0x100, ack tied 1, data=addr: imem_addr_o is 0x100,0x104,0x108 on consecutive cycles -> pc1_o follows one cycle later; ir1_o=NOP_IR during reset.
- isstall1_i=isstall2_i=1 for 3 cycles while ack=1 at addr 0x10C -> ir1/pc1 hold 0x108 values, state S_BUF, req=0; on release pc1_o=0x10C, next addr 0x110, nothing skipped or duplicated.
- isstall1_i=1, isstall2_i=0 for 2 cycles -> ir1_o=0xF000_0000 both cycles, pc_q frozen, then fetch resumes at the held address.
- Ack latency 3, redirect_i to 0x200 one cycle into a request at 0x40 -> addr stays 0x40 until ack, data discarded, ir1_o=NOP_IR, next request addr=0x200.
- redirect_i to 0x300 coincident with ack and isstall2_i=1 -> ir1_o=NOP_IR, pc1_o=0, next addr 0x300, acked data never appears on ir1_o.
- rst_i pulsed asynchronously (between edges) with a request outstanding, then ack arrives -> outputs return to reset values at once, ack ignored, fetch restarts at RESET_PC.
